// File: rtl/ahb_wrapper_pkg.sv
// ahb_wrapper_pkg: shared constants and types for the AHB bridge.
//   - slave register word addresses (status, read start, write start)
//   - master FSM state encoding
//   - pointer step per access and the all-ones busy status word
package ahb_wrapper_pkg;

  localparam logic [31:0] ADDR_STATUS = 32'd0;
  localparam logic [31:0] ADDR_RADDR  = 32'd1;
  localparam logic [31:0] ADDR_WADDR  = 32'd2;

  localparam logic [31:0] ADDR_STEP   = 32'd4;
  localparam logic [31:0] BUSY_WORD   = '1;

  typedef enum logic [2:0] {
    M_IDLE,
    M_RADDR,
    M_RDATA,
    M_WADDR,
    M_WDATA
  } mst_state_e;

endpackage

// File: rtl/ahb_master_ctrl.sv
// ahb_master_ctrl: single-outstanding AHB-Lite master for pixel traffic.
// Latches re/we pulses as pending requests, services them one at a time
// (read before write), auto-increments the read/write pointers.
// Ports:
//   clk, n_rst            clock, synchronous active-high reset
//   re_i, we_i            one-cycle request pulses from the core
//   rptr_ld_i, wptr_ld_i  pointer load strobes from the slave registers
//   ptr_ld_val_i          value loaded by either strobe
//   m_hready_i, m_hrdata_i master bus response
//   buffer2_data_i        write data source (passed through in WDATA)
//   m_haddr_o, m_hwrite_o, m_hwdata_o  master bus request
//   greyscale_data_o      last word read
//   read_complete_o, write_complete_o  one-cycle completion pulses
module ahb_master_ctrl
  import ahb_wrapper_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        re_i,
  input  logic        we_i,
  input  logic        rptr_ld_i,
  input  logic        wptr_ld_i,
  input  logic [31:0] ptr_ld_val_i,
  input  logic        m_hready_i,
  input  logic [31:0] m_hrdata_i,
  input  logic [31:0] buffer2_data_i,
  output logic [31:0] m_haddr_o,
  output logic        m_hwrite_o,
  output logic [31:0] m_hwdata_o,
  output logic [31:0] greyscale_data_o,
  output logic        read_complete_o,
  output logic        write_complete_o
);

  mst_state_e  state_q, state_d;
  logic        rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [31:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, grey_q, grey_d;
  logic        hwrite_q, hwrite_d, rc_q, wc_q;
  logic        rd_take, wr_take, rd_done, wr_done;

  always_comb begin
    state_d = state_q;
    rd_take = 1'b0;
    wr_take = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (rd_pend_q) begin
          state_d = M_RADDR;
          rd_take = 1'b1;
        end else if (wr_pend_q) begin
          state_d = M_WADDR;
          wr_take = 1'b1;
        end
      end
      M_RADDR: if (m_hready_i) state_d = M_RDATA;
      M_RDATA: if (m_hready_i) begin
        state_d = M_IDLE;
        rd_done = 1'b1;
      end
      M_WADDR: if (m_hready_i) state_d = M_WDATA;
      M_WDATA: if (m_hready_i) begin
        state_d = M_IDLE;
        wr_done = 1'b1;
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_comb begin
    // A pulse arriving in the same cycle its flag is consumed stays pending.
    rd_pend_d = (rd_pend_q & ~rd_take) | re_i;
    wr_pend_d = (wr_pend_q & ~wr_take) | we_i;

    // Slave register load takes priority over the post-access increment.
    rptr_d = rptr_q;
    if (rptr_ld_i)    rptr_d = ptr_ld_val_i;
    else if (rd_done) rptr_d = rptr_q + ADDR_STEP;
    wptr_d = wptr_q;
    if (wptr_ld_i)    wptr_d = ptr_ld_val_i;
    else if (wr_done) wptr_d = wptr_q + ADDR_STEP;

    // Address/direction are registered on entry to the address phase so
    // they hold their last value through IDLE.
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    if (rd_take) begin
      haddr_d  = rptr_q;
      hwrite_d = 1'b0;
    end else if (wr_take) begin
      haddr_d  = wptr_q;
      hwrite_d = 1'b1;
    end

    hwdata_d = wr_done ? buffer2_data_i : hwdata_q;
    grey_d   = rd_done ? m_hrdata_i : grey_q;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= M_IDLE;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      grey_q    <= '0;
      rc_q      <= 1'b0;
      wc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      grey_q    <= grey_d;
      rc_q      <= rd_done;
      wc_q      <= wr_done;
    end
  end

  assign m_haddr_o        = haddr_q;
  assign m_hwrite_o       = hwrite_q;
  // Live buffer data during the write data phase, last written word otherwise.
  assign m_hwdata_o       = (state_q == M_WDATA) ? buffer2_data_i : hwdata_q;
  assign greyscale_data_o = grey_q;
  // Registered so the pulse coincides with greyscale_data being valid.
  assign read_complete_o  = rc_q;
  assign write_complete_o = wc_q;

endmodule

// File: rtl/ahb_wrapper.sv
// ahb_wrapper: bridge between the edge-detection core and the AHB fabric.
// Zero-wait-state AHB-Lite slave holding status / RADDR / WADDR registers,
// plus an ahb_master_ctrl instance moving pixel words.
// Ports:
//   clk, n_rst      clock, synchronous active-high reset
//   done            core finished frame, clears busy
//   s_haddr/s_hwrite/s_hwdata -> s_hrdata, s_hready   slave port
//   m_haddr/m_hwrite/m_hwdata <- m_hrdata, m_hready   master port
//   re, we, buffer2_data -> greyscale_data, read_complete, write_complete
// Build option: AHB_WRAPPER_REG_READBACK_EN makes RADDR/WADDR readable at
// slave addresses 1 and 2; without it only status reads back non-zero.
module ahb_wrapper
  import ahb_wrapper_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        done,
  input  logic [31:0] s_haddr,
  input  logic        s_hwrite,
  input  logic [31:0] s_hwdata,
  output logic [31:0] s_hrdata,
  output logic        s_hready,
  output logic [31:0] m_haddr,
  output logic        m_hwrite,
  output logic [31:0] m_hwdata,
  input  logic [31:0] m_hrdata,
  input  logic        m_hready,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] buffer2_data,
  output logic [31:0] greyscale_data,
  output logic        read_complete,
  output logic        write_complete
);

  logic [31:0] addr_q;
  logic        wr_q;
  logic        busy_q, busy_d;
  logic        ld_raddr, ld_waddr;

  // Data phase: the registered address/direction select the target.
  assign ld_raddr = wr_q && (addr_q == ADDR_RADDR);
  assign ld_waddr = wr_q && (addr_q == ADDR_WADDR);

  // A WADDR write in the same cycle as done keeps busy set.
  always_comb begin
    busy_d = busy_q;
    if (ld_waddr)  busy_d = 1'b1;
    else if (done) busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      addr_q <= ADDR_STATUS;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      addr_q <= s_haddr;
      wr_q   <= s_hwrite;
      busy_q <= busy_d;
    end
  end

`ifdef AHB_WRAPPER_REG_READBACK_EN
  logic [31:0] raddr_q, waddr_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      raddr_q <= '0;
      waddr_q <= '0;
    end else begin
      if (ld_raddr) raddr_q <= s_hwdata;
      if (ld_waddr) waddr_q <= s_hwdata;
    end
  end

  always_comb begin
    s_hrdata = '0;
    case (addr_q)
      ADDR_STATUS: s_hrdata = busy_q ? BUSY_WORD : '0;
      ADDR_RADDR:  s_hrdata = raddr_q;
      ADDR_WADDR:  s_hrdata = waddr_q;
      default:     s_hrdata = '0;
    endcase
  end
`else
  always_comb begin
    s_hrdata = '0;
    if (addr_q == ADDR_STATUS) s_hrdata = busy_q ? BUSY_WORD : '0;
  end
`endif

  assign s_hready = 1'b1;

  ahb_master_ctrl u_mst (
    .clk              (clk),
    .n_rst            (n_rst),
    .re_i             (re),
    .we_i             (we),
    .rptr_ld_i        (ld_raddr),
    .wptr_ld_i        (ld_waddr),
    .ptr_ld_val_i     (s_hwdata),
    .m_hready_i       (m_hready),
    .m_hrdata_i       (m_hrdata),
    .buffer2_data_i   (buffer2_data),
    .m_haddr_o        (m_haddr),
    .m_hwrite_o       (m_hwrite),
    .m_hwdata_o       (m_hwdata),
    .greyscale_data_o (greyscale_data),
    .read_complete_o  (read_complete),
    .write_complete_o (write_complete)
  );

endmodule

// File: tb/tb_ahb_wrapper.sv
module tb_ahb_wrapper;

  logic        clk = 1'b0;
  logic        n_rst, done, s_hwrite, s_hready, m_hwrite, m_hready, re, we;
  logic        read_complete, write_complete;
  logic [31:0] s_haddr, s_hwdata, s_hrdata, m_haddr, m_hwdata, m_hrdata;
  logic [31:0] buffer2_data, greyscale_data;

  int checks = 0;
  int errors = 0;

  ahb_wrapper dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .done           (done),
    .s_haddr        (s_haddr),
    .s_hwrite       (s_hwrite),
    .s_hwdata       (s_hwdata),
    .s_hrdata       (s_hrdata),
    .s_hready       (s_hready),
    .m_haddr        (m_haddr),
    .m_hwrite       (m_hwrite),
    .m_hwdata       (m_hwdata),
    .m_hrdata       (m_hrdata),
    .m_hready       (m_hready),
    .re             (re),
    .we             (we),
    .buffer2_data   (buffer2_data),
    .greyscale_data (greyscale_data),
    .read_complete  (read_complete),
    .write_complete (write_complete)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_rb;
  int          stall_pulses;

  initial begin
    n_rst = 1'b1; done = 1'b0; s_haddr = '0; s_hwrite = 1'b0; s_hwdata = '0;
    m_hrdata = '0; m_hready = 1'b1; re = 1'b0; we = 1'b0; buffer2_data = '0;
    step(); step();
    n_rst = 1'b0;

    // Reset state
    chk("rst_s_hrdata", s_hrdata, 32'h0);
    chk("rst_s_hready", {31'b0, s_hready}, 32'h1);
    chk("rst_m_haddr", m_haddr, 32'h0);
    chk("rst_m_hwrite", {31'b0, m_hwrite}, 32'h0);
    chk("rst_m_hwdata", m_hwdata, 32'h0);
    chk("rst_grey", greyscale_data, 32'h0);
    chk("rst_rc_wc", {30'b0, read_complete, write_complete}, 32'h0);

    // Slave config: addr1=0x100 then addr2=0x800 back-to-back
    s_haddr = 32'd1; s_hwrite = 1'b1;
    step();
    s_hwdata = 32'h100; s_haddr = 32'd2; s_hwrite = 1'b1;
    step();
    chk("cfg_hready", {31'b0, s_hready}, 32'h1);
    s_hwdata = 32'h800; s_haddr = 32'd0; s_hwrite = 1'b0;
    step();
    chk("status_busy", s_hrdata, 32'hFFFF_FFFF);
    s_haddr = 32'd1;
    step();
`ifdef AHB_WRAPPER_REG_READBACK_EN
    exp_rb = 32'h100;
`else
    exp_rb = 32'h0;
`endif
    chk("readback_addr1", s_hrdata, exp_rb);
    s_haddr = 32'd3;
    step();
    chk("read_unmapped", s_hrdata, 32'h0);
    s_haddr = 32'd0;
    step();

    // Single read
    m_hrdata = 32'hDEAD_BEEF; re = 1'b1;
    step(); re = 1'b0;
    step();
    chk("rd1_haddr", m_haddr, 32'h100);
    chk("rd1_hwrite", {31'b0, m_hwrite}, 32'h0);
    chk("rd1_no_early_rc", {31'b0, read_complete}, 32'h0);
    step();
    step();
    chk("rd1_rc", {31'b0, read_complete}, 32'h1);
    chk("rd1_grey", greyscale_data, 32'hDEAD_BEEF);
    step();
    chk("rd1_rc_once", {31'b0, read_complete}, 32'h0);

    // Consecutive read
    m_hrdata = 32'h1234_5678; re = 1'b1;
    step(); re = 1'b0;
    step();
    chk("rd2_haddr", m_haddr, 32'h104);
    step(); step();
    chk("rd2_rc", {31'b0, read_complete}, 32'h1);
    chk("rd2_grey", greyscale_data, 32'h1234_5678);

    // Write
    buffer2_data = 32'hCAFE_F00D; we = 1'b1;
    step(); we = 1'b0;
    step();
    chk("wr1_haddr", m_haddr, 32'h800);
    chk("wr1_hwrite", {31'b0, m_hwrite}, 32'h1);
    step();
    chk("wr1_hwdata", m_hwdata, 32'hCAFE_F00D);
    step();
    chk("wr1_wc", {31'b0, write_complete}, 32'h1);
    buffer2_data = 32'h0;
    step();
    chk("wr1_wc_once", {31'b0, write_complete}, 32'h0);
    chk("wr1_hwdata_hold", m_hwdata, 32'hCAFE_F00D);
    chk("wr1_hwrite_hold", {31'b0, m_hwrite}, 32'h1);

    // Next write address
    buffer2_data = 32'h0BAD_F00D; we = 1'b1;
    step(); we = 1'b0;
    step();
    chk("wr2_haddr", m_haddr, 32'h804);
    step(); step();
    chk("wr2_wc", {31'b0, write_complete}, 32'h1);

    // Collision with stall
    m_hready = 1'b0; re = 1'b1; we = 1'b1;
    m_hrdata = 32'hA5A5_A5A5; buffer2_data = 32'h5A5A_5A5A;
    step(); re = 1'b0; we = 1'b0;
    step();
    chk("col_rd_first_haddr", m_haddr, 32'h108);
    chk("col_rd_first_hwrite", {31'b0, m_hwrite}, 32'h0);
    stall_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      stall_pulses += int'(read_complete) + int'(write_complete);
    end
    chk("col_stall_no_pulse", stall_pulses, 32'd0);
    m_hready = 1'b1;
    step(); step();
    chk("col_rc", {30'b0, read_complete, write_complete}, 32'h2);
    chk("col_grey", greyscale_data, 32'hA5A5_A5A5);
    step();
    chk("col_wr_haddr", m_haddr, 32'h808);
    chk("col_wr_hwrite", {31'b0, m_hwrite}, 32'h1);
    step(); step();
    chk("col_wc", {30'b0, read_complete, write_complete}, 32'h1);
    chk("col_hwdata", m_hwdata, 32'h5A5A_5A5A);

    // done clears busy
    chk("status_pre_done", s_hrdata, 32'hFFFF_FFFF);
    done = 1'b1;
    step(); done = 1'b0;
    chk("status_after_done", s_hrdata, 32'h0);

    // Reset during RDATA
    m_hrdata = 32'h1111_1111; re = 1'b1;
    step(); re = 1'b0;
    step(); step();
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    chk("mid_rst_rc", {31'b0, read_complete}, 32'h0);
    chk("mid_rst_grey", greyscale_data, 32'h0);
    chk("mid_rst_haddr", m_haddr, 32'h0);
    chk("mid_rst_hwdata", m_hwdata, 32'h0);
    chk("mid_rst_hwrite", {31'b0, m_hwrite}, 32'h0);
    // FSM idle and pointers cleared: a fresh read starts from address 0
    m_hrdata = 32'h2222_2222; re = 1'b1;
    step(); re = 1'b0;
    step();
    chk("post_rst_rd_haddr", m_haddr, 32'h0);
    step(); step();
    chk("post_rst_rc", {31'b0, read_complete}, 32'h1);
    chk("post_rst_grey", greyscale_data, 32'h2222_2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
